// File: rtl/uart_imem_loader_pkg.sv
// Shared definitions for the UART boot loader: loader/receiver state encodings
// and UART frame constants (also intended for a future UART transmitter).
package uart_imem_loader_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LEN_LO,
        ST_LEN_HI,
        ST_DATA,
        ST_DONE,
        ST_ERR
    } loader_state_t;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP
    } rx_state_t;

    localparam int DATA_BITS = 8;
    localparam int STOP_BITS = 1;

endpackage

// File: rtl/uart_rx_core.sv
// 8N1 UART receiver: synchroniser, mid-bit sampling timer and frame FSM.
// Emits one-cycle byte_vld for good frames and one-cycle ferr for bad stop bits.
module uart_rx_core
    import uart_imem_loader_pkg::*;
#(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rx,
    output logic                 byte_vld,
    output logic [DATA_BITS-1:0] byte_data,
    output logic                 ferr
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam int BI_W  = $clog2(DATA_BITS);
    localparam logic [CNT_W-1:0] HALF_LAST    = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] BIT_LAST     = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [BI_W-1:0]  BIT_IDX_LAST = BI_W'(DATA_BITS - 1);

    rx_state_t            state, state_nxt;
    logic                 rx_meta, rx_sync, rx_prev;
    logic                 fall, bit_tick;
    logic [CNT_W-1:0]     cnt;
    logic [BI_W-1:0]      bit_idx;
    logic [DATA_BITS-1:0] shreg;

    // The line idles high, so the synchroniser resets to 1 to avoid a false start.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_sync <= rx_meta;
            rx_prev <= rx_sync;
        end
    end

    assign fall     = rx_prev & ~rx_sync;
    assign bit_tick = (cnt == BIT_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= RX_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            RX_IDLE:  if (fall) state_nxt = RX_START;
            RX_START: if (cnt == HALF_LAST) state_nxt = rx_sync ? RX_IDLE : RX_DATA;
            RX_DATA:  if (bit_tick && bit_idx == BIT_IDX_LAST) state_nxt = RX_STOP;
            RX_STOP:  if (bit_tick) state_nxt = RX_IDLE;
            default:  state_nxt = RX_IDLE;
        endcase
    end

    // Timer restarts on every state change and after every data-bit sample.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt       <= '0;
            bit_idx   <= '0;
            shreg     <= '0;
            byte_data <= '0;
            byte_vld  <= 1'b0;
            ferr      <= 1'b0;
        end else begin
            byte_vld <= 1'b0;
            ferr     <= 1'b0;
            if (state == RX_IDLE || state_nxt != state || bit_tick) cnt <= '0;
            else                                                   cnt <= cnt + 1'b1;
            if (state == RX_START) bit_idx <= '0;
            if (state == RX_DATA && bit_tick) begin
                shreg   <= {rx_sync, shreg[DATA_BITS-1:1]};
                bit_idx <= bit_idx + 1'b1;
            end
            if (state == RX_STOP && bit_tick) begin
                if (rx_sync) begin
                    byte_vld  <= 1'b1;
                    byte_data <= shreg;
                end else begin
                    ferr <= 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/uart_imem_loader.sv
// UART boot loader: parses a length-prefixed image from the serial line and
// writes it word by word into instruction memory while holding the CPU.
module uart_imem_loader
    import uart_imem_loader_pkg::*;
#(
    parameter int CLKS_PER_BIT = 868,
    parameter int ADDR_W       = 14,
    parameter int MAX_WORDS    = 16384,
    parameter int TIMEOUT_CYC  = 1000000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              rx,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              hold,
    output logic              done,
    output logic              err
);

    localparam int TO_W = $clog2(TIMEOUT_CYC);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYC - 1);

    loader_state_t   state, state_nxt;
    logic            start_meta, start_sync, start_prev, start_edge;
    logic            byte_vld, ferr;
    logic [7:0]      byte_data;
    logic [15:0]     len, len_full, word_cnt;
    logic [1:0]      byte_idx;
    logic [31:0]     word_buf;
    logic [TO_W-1:0] to_cnt;
    logic            loading, timeout, last_word;

    uart_rx_core #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_rx (
        .clk      (clk),
        .rst      (rst),
        .rx       (rx),
        .byte_vld (byte_vld),
        .byte_data(byte_data),
        .ferr     (ferr)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            start_meta <= 1'b0;
            start_sync <= 1'b0;
            start_prev <= 1'b0;
        end else begin
            start_meta <= start;
            start_sync <= start_meta;
            start_prev <= start_sync;
        end
    end

    assign start_edge = start_sync & ~start_prev;
    assign loading    = (state == ST_LEN_LO) || (state == ST_LEN_HI) || (state == ST_DATA);
    assign timeout    = loading && !byte_vld && (to_cnt == TO_LAST);
    assign len_full   = {byte_data, len[7:0]};
    assign last_word  = (byte_idx == 2'd3) && (word_cnt == len - 16'd1);

    assign hold = loading || (state == ST_ERR);
    assign done = (state == ST_DONE);
    assign err  = (state == ST_ERR);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nxt;
    end

    // Start edges are only honoured outside a load; in those states any byte is dropped.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE, ST_DONE, ST_ERR: begin
                if (start_edge) state_nxt = ST_LEN_LO;
            end
            ST_LEN_LO: begin
                if (ferr || timeout) state_nxt = ST_ERR;
                else if (byte_vld)   state_nxt = ST_LEN_HI;
            end
            ST_LEN_HI: begin
                if (ferr || timeout) state_nxt = ST_ERR;
                else if (byte_vld) begin
                    if (len_full == 16'd0)                      state_nxt = ST_DONE;
                    else if ({1'b0, len_full} > 17'(MAX_WORDS)) state_nxt = ST_ERR;
                    else                                        state_nxt = ST_DATA;
                end
            end
            ST_DATA: begin
                if (ferr || timeout)           state_nxt = ST_ERR;
                else if (byte_vld && last_word) state_nxt = ST_DONE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // The word strobe is registered, so it lands in the same cycle the FSM enters DONE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            imem_we    <= 1'b0;
            imem_addr  <= '0;
            imem_wdata <= '0;
            len        <= '0;
            word_cnt   <= '0;
            byte_idx   <= '0;
            word_buf   <= '0;
            to_cnt     <= '0;
        end else begin
            imem_we <= 1'b0;
            if (!loading || byte_vld || (state_nxt == ST_LEN_LO && state != ST_LEN_LO))
                to_cnt <= '0;
            else
                to_cnt <= to_cnt + 1'b1;
            case (state)
                ST_LEN_LO: if (byte_vld) len[7:0] <= byte_data;
                ST_LEN_HI: begin
                    if (byte_vld) begin
                        len[15:8] <= byte_data;
                        word_cnt  <= '0;
                        byte_idx  <= '0;
                        word_buf  <= '0;
                    end
                end
                ST_DATA: begin
                    if (byte_vld) begin
                        word_buf <= {byte_data, word_buf[31:8]};
                        byte_idx <= byte_idx + 1'b1;
                        if (byte_idx == 2'd3) begin
                            imem_we    <= 1'b1;
                            imem_addr  <= word_cnt[ADDR_W-1:0];
                            imem_wdata <= {byte_data, word_buf[31:8]};
                            word_cnt   <= word_cnt + 16'd1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_imem_loader.sv
// Self-checking bench for uart_imem_loader: table-driven image loads with random
// payloads checked against an image-level model, plus hand-written corner sequences.
module tb_uart_imem_loader;
    import uart_imem_loader_pkg::*;

    localparam int CPB  = 16;
    localparam int AW   = 8;
    localparam int MAXW = 64;
    localparam int TO   = 2000;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic          rx;
    logic          imem_we;
    logic [AW-1:0] imem_addr;
    logic [31:0]   imem_wdata;
    logic          hold;
    logic          done;
    logic          err;

    uart_imem_loader #(
        .CLKS_PER_BIT(CPB),
        .ADDR_W      (AW),
        .MAX_WORDS   (MAXW),
        .TIMEOUT_CYC (TO)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .rx        (rx),
        .imem_we   (imem_we),
        .imem_addr (imem_addr),
        .imem_wdata(imem_wdata),
        .hold      (hold),
        .done      (done),
        .err       (err)
    );

    always #5 clk = ~clk;

    typedef struct {
        int hdr_n;
        int n_payload;
        int bad_idx;
        bit exp_done;
        bit exp_err;
        bit exp_hold;
        int exp_writes;
    } vec_t;

    vec_t vecs[10];

    int checks = 0;
    int passes = 0;

    // Write strobes observed on the memory port
    logic [AW-1:0] got_addr[$];
    logic [31:0]   got_data[$];
    logic          got_done[$];
    int            bad_done_hold = 0;

    // Stimulus stream and model results
    logic [7:0]    stream[$];
    int            bad_pos;
    bit            m_done, m_err;
    logic [AW-1:0] m_addr[$];
    logic [31:0]   m_data[$];

    always @(negedge clk) begin
        if (imem_we) begin
            got_addr.push_back(imem_addr);
            got_data.push_back(imem_wdata);
            got_done.push_back(done);
        end
        if (!rst && done && hold) bad_done_hold++;
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual === expected) passes++;
        else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    endtask

    // Image-level model: header gives N words, each word is 4 little-endian bytes;
    // a bad or missing byte aborts the image after the words completed before it.
    function automatic void runModel();
        int n, base, n_sent;
        n_sent = stream.size();
        m_addr.delete();
        m_data.delete();
        m_done = 1'b0;
        m_err  = 1'b0;
        if (n_sent < 2 || bad_pos == 0 || bad_pos == 1) begin
            m_err = 1'b1;
            return;
        end
        n = int'(stream[0]) + 256 * int'(stream[1]);
        if (n == 0) begin
            m_done = 1'b1;
            return;
        end
        if (n > MAXW) begin
            m_err = 1'b1;
            return;
        end
        for (int w = 0; w < n; w++) begin
            base = 2 + 4 * w;
            if (base + 3 >= n_sent || (bad_pos >= base && bad_pos <= base + 3)) begin
                m_err = 1'b1;
                return;
            end
            m_addr.push_back(AW'(w % (1 << AW)));
            m_data.push_back({stream[base+3], stream[base+2], stream[base+1], stream[base]});
        end
        m_done = 1'b1;
    endfunction

    task automatic sendByte(input logic [7:0] b, input bit good_stop);
        rx = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < DATA_BITS; i++) begin
            rx = b[i];
            repeat (CPB) @(negedge clk);
        end
        for (int i = 0; i < STOP_BITS; i++) begin
            rx = good_stop;
            repeat (CPB) @(negedge clk);
        end
        rx = 1'b1;
        repeat (CPB) @(negedge clk);
    endtask

    task automatic sendStream();
        for (int i = 0; i < stream.size(); i++) sendByte(stream[i], i != bad_pos);
    endtask

    task automatic pulseStart();
        start = 1'b1;
        repeat (4) @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic clearCapture();
        got_addr.delete();
        got_data.delete();
        got_done.delete();
    endtask

    task automatic compareWrites(input string tag);
        int n;
        checkOutput({tag, "_nwrites_model"}, 32'(got_addr.size()), 32'(m_addr.size()));
        n = (got_addr.size() < m_addr.size()) ? got_addr.size() : m_addr.size();
        for (int i = 0; i < n; i++) begin
            checkOutput($sformatf("%s_addr%0d", tag, i), 32'(got_addr[i]), 32'(m_addr[i]));
            checkOutput($sformatf("%s_data%0d", tag, i), got_data[i], m_data[i]);
        end
    endtask

    task automatic applyStimulus(input vec_t v, input int row);
        int needed;
        string tag;
        tag = $sformatf("row%0d", row);
        clearCapture();
        stream.delete();
        stream.push_back(8'(v.hdr_n));
        if (v.bad_idx != 0) stream.push_back(8'(v.hdr_n >> 8));
        for (int p = 0; p < v.n_payload; p++) stream.push_back(8'($urandom_range(0, 255)));
        bad_pos = v.bad_idx;
        pulseStart();
        checkOutput({tag, "_hold_on_start"}, 32'(hold), 32'd1);
        checkOutput({tag, "_done_clr"}, 32'(done), 32'd0);
        checkOutput({tag, "_err_clr"}, 32'(err), 32'd0);
        sendStream();
        runModel();
        needed = (v.hdr_n == 0 || v.hdr_n > MAXW) ? 0 : 4 * v.hdr_n;
        if (v.bad_idx < 0 && v.n_payload < needed) repeat (TO + 200) @(negedge clk);
        else                                        repeat (60) @(negedge clk);
        checkOutput({tag, "_done"}, 32'(done), 32'(v.exp_done));
        checkOutput({tag, "_err"}, 32'(err), 32'(v.exp_err));
        checkOutput({tag, "_hold"}, 32'(hold), 32'(v.exp_hold));
        checkOutput({tag, "_nwrites"}, 32'(got_addr.size()), 32'(v.exp_writes));
        checkOutput({tag, "_model_done"}, 32'(done), 32'(m_done));
        compareWrites(tag);
        if (v.exp_done && v.exp_writes > 0)
            checkOutput({tag, "_done_at_last_we"},
                        32'((got_done.size() > 0) ? got_done[got_done.size()-1] : 1'b0), 32'd1);
    endtask

    initial begin
        #3_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        vecs[0] = '{1,  4,  -1, 1'b1, 1'b0, 1'b0, 1};
        vecs[1] = '{3,  12, -1, 1'b1, 1'b0, 1'b0, 3};
        vecs[2] = '{0,  0,  -1, 1'b1, 1'b0, 1'b0, 0};
        vecs[3] = '{65, 0,  -1, 1'b0, 1'b1, 1'b1, 0};
        vecs[4] = '{1,  3,  4,  1'b0, 1'b1, 1'b1, 0};
        vecs[5] = '{5,  9,  10, 1'b0, 1'b1, 1'b1, 2};
        vecs[6] = '{2,  0,  1,  1'b0, 1'b1, 1'b1, 0};
        vecs[7] = '{1,  2,  -1, 1'b0, 1'b1, 1'b1, 0};
        vecs[8] = '{64, 4,  -1, 1'b0, 1'b1, 1'b1, 1};
        vecs[9] = '{4,  16, -1, 1'b1, 1'b0, 1'b0, 4};

        rst   = 1'b1;
        start = 1'b0;
        rx    = 1'b1;
        repeat (4) @(negedge clk);
        checkOutput("reset_flags", {28'd0, imem_we, hold, done, err}, 32'd0);
        checkOutput("reset_addr", 32'(imem_addr), 32'd0);
        checkOutput("reset_wdata", imem_wdata, 32'd0);
        rst = 1'b0;
        repeat (4) @(negedge clk);

        // Reference image with known instruction words
        clearCapture();
        stream = '{8'h02, 8'h00, 8'h13, 8'h05, 8'h10, 8'h00, 8'h73, 8'h00, 8'h00, 8'h00};
        bad_pos = -1;
        pulseStart();
        sendStream();
        repeat (60) @(negedge clk);
        checkOutput("img1_nwrites", 32'(got_addr.size()), 32'd2);
        checkOutput("img1_addr0", 32'(got_addr[0]), 32'd0);
        checkOutput("img1_data0", got_data[0], 32'h00100513);
        checkOutput("img1_addr1", 32'(got_addr[1]), 32'd1);
        checkOutput("img1_data1", got_data[1], 32'h00000073);
        checkOutput("img1_done", 32'(done), 32'd1);
        checkOutput("img1_hold", 32'(hold), 32'd0);

        for (int r = 0; r < 10; r++) applyStimulus(vecs[r], r);

        // Reset in the middle of a word discards it; the next load starts at address 0
        clearCapture();
        stream = '{8'h01, 8'h00, 8'hAA, 8'hBB};
        bad_pos = -1;
        pulseStart();
        sendStream();
        rst = 1'b1;
        #1;
        checkOutput("midrst_flags", {28'd0, imem_we, hold, done, err}, 32'd0);
        checkOutput("midrst_addr", 32'(imem_addr), 32'd0);
        checkOutput("midrst_wdata", imem_wdata, 32'd0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        checkOutput("midrst_nwrites_before", 32'(got_addr.size()), 32'd0);
        stream = '{8'h01, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44};
        pulseStart();
        sendStream();
        repeat (60) @(negedge clk);
        checkOutput("rst_reload_nwrites", 32'(got_addr.size()), 32'd1);
        checkOutput("rst_reload_addr", 32'(got_addr[0]), 32'd0);
        checkOutput("rst_reload_data", got_data[0], 32'h44332211);
        checkOutput("rst_reload_done", 32'(done), 32'd1);

        // Start edge during DATA must not disturb the load
        clearCapture();
        stream.delete();
        stream.push_back(8'h02);
        stream.push_back(8'h00);
        for (int i = 0; i < 8; i++) stream.push_back(8'($urandom_range(0, 255)));
        bad_pos = -1;
        pulseStart();
        for (int i = 0; i < 6; i++) sendByte(stream[i], 1'b1);
        pulseStart();
        checkOutput("midstart_hold", 32'(hold), 32'd1);
        for (int i = 6; i < 10; i++) sendByte(stream[i], 1'b1);
        repeat (60) @(negedge clk);
        runModel();
        checkOutput("midstart_done", 32'(done), 32'd1);
        checkOutput("midstart_nwrites", 32'(got_addr.size()), 32'd2);
        compareWrites("midstart");

        // Long idle gap after one payload byte trips the timeout
        clearCapture();
        stream = '{8'h01, 8'h00, 8'h5A};
        pulseStart();
        sendStream();
        repeat (2500) @(negedge clk);
        checkOutput("gap_err", 32'(err), 32'd1);
        checkOutput("gap_hold", 32'(hold), 32'd1);
        checkOutput("gap_done", 32'(done), 32'd0);
        checkOutput("gap_nwrites", 32'(got_addr.size()), 32'd0);

        checkOutput("done_hold_overlap", 32'(bad_done_hold), 32'd0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
